// File: rtl/link_sched_pkg.sv
// Shared types and sizing helpers for the link scheduler.
package link_sched_pkg;

  localparam int DATA_W_DEF = 16;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ARB    = 3'd1,
    S_LAUNCH = 3'd2,
    S_WAIT   = 3'd3,
    S_RESP   = 3'd4,
    S_GAP    = 3'd5
  } state_t;

  // Requester ID width; never narrower than one bit.
  function automatic int id_w(input int n);
    if (n <= 2) return 1;
    else return $clog2(n);
  endfunction

  // Width of the shared counter: must hold the largest terminal count.
  function automatic int cnt_w(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (m < 1) m = 1;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/link_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first active request after the pointer wins.
module rr_arbiter
#(
  parameter int NREQ = 2,
  parameter int IDW  = 1
)(
  input  logic [NREQ-1:0] i_req,
  input  logic [IDW-1:0]  i_ptr,
  output logic [NREQ-1:0] o_grant,
  output logic [IDW-1:0]  o_idx
);

  // Scan downward so the candidate closest to ptr+1 is written last and wins.
  always_comb begin
    int j;
    j       = 0;
    o_grant = '0;
    o_idx   = '0;
    for (int k = NREQ; k >= 1; k--) begin
      j = (int'(i_ptr) + k) % NREQ;
      if (i_req[j]) begin
        o_grant    = '0;
        o_grant[j] = 1'b1;
        o_idx      = IDW'(j);
      end else begin
        o_idx = o_idx;
      end
    end
  end

endmodule

// File: rtl/link_scheduler.sv
// One-transfer-at-a-time scheduler for the encode/transmit/receive/decode link.
// Optional macro LINK_SCHED_CHECK_EN adds rsp_mismatch and a saturating err_count.
module link_scheduler
  import link_sched_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int NREQ        = 2,
  parameter int START_CYC   = 3,
  parameter int TIMEOUT_CYC = 4095,
  parameter int GAP_CYC     = 4
)(
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*DATA_W-1:0] req_data,
  output logic [NREQ-1:0]        req_ready,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [DATA_W-1:0]      rsp_data,
  output logic [id_w(NREQ)-1:0]  rsp_id,
  output logic                   rsp_timeout,
  output logic [DATA_W-1:0]      link_data,
  output logic                   link_start,
  input  logic                   link_done,
  input  logic [DATA_W-1:0]      link_rdata,
  output logic                   busy
`ifdef LINK_SCHED_CHECK_EN
  ,
  output logic                   rsp_mismatch,
  output logic [15:0]            err_count
`endif
);

  localparam int IDW = id_w(NREQ);
  localparam int CW  = cnt_w(TIMEOUT_CYC, START_CYC, GAP_CYC);

  state_t              r_state;
  logic [IDW-1:0]      r_ptr;
  logic [CW-1:0]       r_cnt;
  logic [NREQ-1:0]     r_req_ready;
  logic                r_rsp_valid;
  logic [DATA_W-1:0]   r_rsp_data;
  logic [IDW-1:0]      r_rsp_id;
  logic                r_rsp_timeout;
  logic [DATA_W-1:0]   r_link_data;
  logic                r_link_start;
  logic                r_busy;
  logic [NREQ-1:0]     w_grant;
  logic [IDW-1:0]      w_idx;
  logic [DATA_W-1:0]   w_sel_data;
  logic [CW-1:0]       w_cnt_nxt;
`ifdef LINK_SCHED_CHECK_EN
  logic                r_mismatch;
  logic [15:0]         r_err_count;
`endif

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .i_req   (req_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx)
  );

  assign w_sel_data = req_data[w_idx*DATA_W +: DATA_W];
  assign w_cnt_nxt  = r_cnt + CW'(1);

  // Transfer sequencer: grant, strobe, wait for decode, respond, settle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_ptr         <= '0;
      r_cnt         <= '0;
      r_req_ready   <= '0;
      r_rsp_valid   <= 1'b0;
      r_rsp_data    <= '0;
      r_rsp_id      <= '0;
      r_rsp_timeout <= 1'b0;
      r_link_data   <= '0;
      r_link_start  <= 1'b0;
      r_busy        <= 1'b0;
`ifdef LINK_SCHED_CHECK_EN
      r_mismatch    <= 1'b0;
      r_err_count   <= 16'd0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          // Grant is resolved here so req_ready is a clean registered pulse in ARB.
          if (|req_valid) begin
            r_req_ready <= w_grant;
            r_rsp_id    <= w_idx;
            r_ptr       <= w_idx;
            r_link_data <= w_sel_data;
            r_busy      <= 1'b1;
            r_state     <= S_ARB;
          end
        end
        S_ARB: begin
          r_req_ready <= '0;
          r_cnt       <= '0;
          if (START_CYC == 0) begin
            r_state <= S_WAIT;
          end else begin
            r_link_start <= 1'b1;
            r_state      <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          // link_done is deliberately not looked at: it may be left over from the last word.
          if (r_cnt == CW'(START_CYC - 1)) begin
            r_link_start <= 1'b0;
            r_cnt        <= '0;
            r_state      <= S_WAIT;
          end else begin
            r_cnt <= w_cnt_nxt;
          end
        end
        S_WAIT: begin
          if (link_done) begin
            r_rsp_data    <= link_rdata;
            r_rsp_timeout <= 1'b0;
            r_rsp_valid   <= 1'b1;
            r_state       <= S_RESP;
`ifdef LINK_SCHED_CHECK_EN
            r_mismatch    <= (link_rdata != r_link_data);
`endif
          end else if (w_cnt_nxt == CW'(TIMEOUT_CYC)) begin
            r_rsp_data    <= '0;
            r_rsp_timeout <= 1'b1;
            r_rsp_valid   <= 1'b1;
            r_state       <= S_RESP;
`ifdef LINK_SCHED_CHECK_EN
            r_mismatch    <= 1'b0;
`endif
          end else begin
            r_cnt <= w_cnt_nxt;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_cnt       <= '0;
`ifdef LINK_SCHED_CHECK_EN
            r_mismatch  <= 1'b0;
            if ((r_mismatch || r_rsp_timeout) && (r_err_count != 16'hFFFF)) begin
              r_err_count <= r_err_count + 16'd1;
            end
`endif
            if (GAP_CYC == 0) begin
              r_busy  <= 1'b0;
              r_state <= S_IDLE;
            end else begin
              r_state <= S_GAP;
            end
          end
        end
        S_GAP: begin
          if (r_cnt == CW'(GAP_CYC - 1)) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= w_cnt_nxt;
          end
        end
        default: begin
          r_req_ready  <= '0;
          r_rsp_valid  <= 1'b0;
          r_link_start <= 1'b0;
          r_busy       <= 1'b0;
          r_state      <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ready   = r_req_ready;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_data    = r_rsp_data;
  assign rsp_id      = r_rsp_id;
  assign rsp_timeout = r_rsp_timeout;
  assign link_data   = r_link_data;
  assign link_start  = r_link_start;
  assign busy        = r_busy;
`ifdef LINK_SCHED_CHECK_EN
  assign rsp_mismatch = r_mismatch;
  assign err_count    = r_err_count;
`endif

endmodule

// File: tb/tb_link_scheduler.sv
// Directed, table-driven bench for link_scheduler (two instances: default timeout and 20-cycle timeout).
module tb_link_scheduler;

  localparam int START = 3;
  localparam int GAP   = 4;
  localparam int TO0   = 4095;
  localparam int TO1   = 20;

  typedef struct {
    int          u;
    logic [1:0]  valid;
    logic [15:0] d0;
    logic [15:0] d1;
    int          delay;     // WAIT cycle in which link_done is seen; 0 = never
    logic [15:0] rdata;
    int          bp;        // cycles rsp_ready is held low
    bit          stale;     // link_done held high through LAUNCH
    bit          rst_mid;   // reset asserted in WAIT
    int          exp_id;
    logic [15:0] exp_data;
    bit          exp_to;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  r_valid [0:1];
  logic [31:0] r_data  [0:1];
  logic [1:0]  rdy     [0:1];
  logic        rvalid  [0:1];
  logic        r_ready [0:1];
  logic [15:0] rdata_o [0:1];
  logic        rid     [0:1];
  logic        rto     [0:1];
  logic [15:0] ldata   [0:1];
  logic        lstart  [0:1];
  logic        l_done  [0:1];
  logic [15:0] l_rdata [0:1];
  logic        busy    [0:1];
`ifdef LINK_SCHED_CHECK_EN
  logic        mm      [0:1];
  logic [15:0] errc    [0:1];
  int          errs    [0:1];
`endif

  int checks = 0;
  int errors = 0;
  int cur = -1;
  vec_t vecs [13];

  always #5 clk = ~clk;

  link_scheduler u_dut0 (
    .clk(clk), .reset(reset), .req_valid(r_valid[0]), .req_data(r_data[0]), .req_ready(rdy[0]),
    .rsp_valid(rvalid[0]), .rsp_ready(r_ready[0]), .rsp_data(rdata_o[0]), .rsp_id(rid[0]),
    .rsp_timeout(rto[0]), .link_data(ldata[0]), .link_start(lstart[0]), .link_done(l_done[0]),
    .link_rdata(l_rdata[0]), .busy(busy[0])
`ifdef LINK_SCHED_CHECK_EN
    , .rsp_mismatch(mm[0]), .err_count(errc[0])
`endif
  );

  link_scheduler #(.TIMEOUT_CYC(TO1)) u_dut1 (
    .clk(clk), .reset(reset), .req_valid(r_valid[1]), .req_data(r_data[1]), .req_ready(rdy[1]),
    .rsp_valid(rvalid[1]), .rsp_ready(r_ready[1]), .rsp_data(rdata_o[1]), .rsp_id(rid[1]),
    .rsp_timeout(rto[1]), .link_data(ldata[1]), .link_start(lstart[1]), .link_done(l_done[1]),
    .link_rdata(l_rdata[1]), .busy(busy[1])
`ifdef LINK_SCHED_CHECK_EN
    , .rsp_mismatch(mm[1]), .err_count(errc[1])
`endif
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL v%0d %s: actual %0d required %0d", cur, name, act, exp);
    end
  endtask

  task automatic chk_zero(input int u, input string tag);
    check({tag, "_data"}, {ldata[u], rdata_o[u]}, 32'd0);
    check({tag, "_ctl"}, 32'({rdy[u], rvalid[u], rid[u], rto[u], lstart[u], busy[u]}), 32'd0);
`ifdef LINK_SCHED_CHECK_EN
    check({tag, "_chk"}, 32'({mm[u], errc[u]}), 32'd0);
`endif
  endtask

  task automatic run_vec(input vec_t v);
    int u, n, lat, exp_lat;
    logic [15:0] word;
    logic [1:0]  oh;
`ifdef LINK_SCHED_CHECK_EN
    bit exp_mm;
`endif
    u       = v.u;
    word    = (v.exp_id == 0) ? v.d0 : v.d1;
    oh      = (v.exp_id == 0) ? 2'b01 : 2'b10;
    exp_lat = 1 + START + ((v.delay > 0) ? v.delay : ((u == 0) ? TO0 : TO1));
    r_valid[u] = v.valid;
    r_data[u]  = {v.d1, v.d0};
    if (v.stale) l_done[u] = 1'b1;
    n = 0;
    while (rdy[u] == 2'b00 && n < 30) begin tick(); n++; end
    check("grant", 32'(rdy[u]), 32'(oh));
    check("link_data", 32'(ldata[u]), 32'(word));
    r_valid[u][v.exp_id] = 1'b0;
    lat = 0;
    n   = 0;
    tick(); lat++;
    while (lstart[u] && n < 10) begin
      if (ldata[u] != word) check("link_data_hold", 32'(ldata[u]), 32'(word));
      n++; tick(); lat++;
    end
    check("start_len", 32'(n), 32'(START));
    if (v.stale) l_done[u] = 1'b0;
    if (v.rst_mid) begin
      tick(); tick();
      reset = 1'b0;
      #1;
      chk_zero(u, "rst_now");
      tick(); tick();
      chk_zero(u, "rst_hold");
      reset = 1'b1;
`ifdef LINK_SCHED_CHECK_EN
      errs[0] = 0; errs[1] = 0;
`endif
      r_valid[u] = 2'b00;
      tick();
      check("rst_idle", 32'({busy[u], rvalid[u]}), 32'd0);
      return;
    end
    if (v.delay > 0) begin
      repeat (v.delay - 1) begin tick(); lat++; end
      l_done[u]  = 1'b1;
      l_rdata[u] = v.rdata;
    end
    n = 0;
    while (!rvalid[u] && n < 5000) begin tick(); lat++; n++; end
    l_done[u] = 1'b0;
    check("rsp_valid", 32'(rvalid[u]), 32'd1);
    check("latency", 32'(lat), 32'(exp_lat));
    check("rsp_data", 32'(rdata_o[u]), 32'(v.exp_data));
    check("rsp_id", 32'(rid[u]), 32'(v.exp_id));
    check("rsp_timeout", 32'(rto[u]), 32'(v.exp_to));
`ifdef LINK_SCHED_CHECK_EN
    exp_mm = (v.rdata != word) && !v.exp_to;
    check("rsp_mismatch", 32'(mm[u]), 32'(exp_mm));
`endif
    for (int i = 0; i < v.bp; i++) begin
      tick();
      check("bp_hold", {rdata_o[u], 8'd0, 3'd0, rvalid[u], rto[u], rid[u], rdy[u]},
            {v.exp_data, 8'd0, 3'd0, 1'b1, 1'(v.exp_to), 1'(v.exp_id), 2'b00});
    end
    r_ready[u] = 1'b1;
    tick();
    r_ready[u] = 1'b0;
    check("rsp_drop", 32'(rvalid[u]), 32'd0);
`ifdef LINK_SCHED_CHECK_EN
    if (exp_mm || v.exp_to) errs[u]++;
    check("err_count", 32'(errc[u]), 32'(errs[u]));
`endif
    n = 0;
    while (busy[u] && n < 20) begin
      if (rdy[u] != 2'b00) check("gap_grant", 32'(rdy[u]), 32'd0);
      tick(); n++;
    end
    check("gap_len", 32'(n), 32'(GAP));
    r_valid[u] = 2'b00;
  endtask

  initial begin
    //          u  valid  d0        d1        dly rdata     bp stl rst id data      to
    vecs[0]  = '{0, 2'b01, 16'd12345, 16'd0,     40, 16'd12345, 0, 1'b0, 1'b0, 0, 16'd12345, 1'b0};
    vecs[1]  = '{0, 2'b10, 16'd0,     16'd777,   1,  16'd777,   0, 1'b0, 1'b0, 1, 16'd777,   1'b0};
    vecs[2]  = '{0, 2'b01, 16'hFFFF,  16'd0,     5,  16'hA5A5,  0, 1'b1, 1'b0, 0, 16'hA5A5,  1'b0};
    vecs[3]  = '{0, 2'b11, 16'd10101, 16'd12345, 3,  16'd12345, 0, 1'b0, 1'b0, 1, 16'd12345, 1'b0};
    vecs[4]  = '{0, 2'b11, 16'd10101, 16'd12345, 3,  16'd10101, 0, 1'b0, 1'b0, 0, 16'd10101, 1'b0};
    vecs[5]  = '{0, 2'b11, 16'd10101, 16'd12345, 2,  16'd12345, 10, 1'b0, 1'b0, 1, 16'd12345, 1'b0};
    vecs[6]  = '{0, 2'b11, 16'd10101, 16'd12345, 2,  16'd10101, 0, 1'b0, 1'b0, 0, 16'd10101, 1'b0};
    vecs[7]  = '{1, 2'b01, 16'd4321,  16'd0,     0,  16'd0,     0, 1'b0, 1'b0, 0, 16'd0,     1'b1};
    vecs[8]  = '{1, 2'b10, 16'd0,     16'd99,    2,  16'd99,    0, 1'b0, 1'b0, 1, 16'd99,    1'b0};
    vecs[9]  = '{0, 2'b10, 16'd0,     16'd555,   0,  16'd0,     0, 1'b0, 1'b1, 1, 16'd0,     1'b0};
    vecs[10] = '{0, 2'b01, 16'd12345, 16'd0,     4,  16'd12345, 0, 1'b0, 1'b0, 0, 16'd12345, 1'b0};
    vecs[11] = '{0, 2'b11, 16'd10101, 16'd12345, 2,  16'd12345, 0, 1'b0, 1'b0, 1, 16'd12345, 1'b0};
    vecs[12] = '{0, 2'b01, 16'd12345, 16'd0,     3,  16'd12344, 0, 1'b0, 1'b0, 0, 16'd12344, 1'b0};

    for (int u = 0; u < 2; u++) begin
      r_valid[u] = 2'b00; r_data[u] = 32'd0; r_ready[u] = 1'b0;
      l_done[u] = 1'b0; l_rdata[u] = 16'd0;
`ifdef LINK_SCHED_CHECK_EN
      errs[u] = 0;
`endif
    end
    reset = 1'b0;
    tick(); tick();
    chk_zero(0, "reset0");
    chk_zero(1, "reset1");
    reset = 1'b1;
    tick();
    check("idle_after_reset", 32'({busy[0], busy[1]}), 32'd0);

    for (int i = 0; i < 13; i++) begin
      cur = i;
      run_vec(vecs[i]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/link_scheduler.md
Name: link_scheduler

Overview:
- Sequences one transfer at a time through the shared Hamming-encode → raised-cosine transmit → receive → Hamming-decode link.
- Arbitrates between NREQ requester ports and launches each word with a held start strobe.
- Waits for the decoder's write-ready, with a timeout, and returns the decoded word tagged with the requester ID.
- Sits between host-side requesters and the link's readready/writeready handshakes.

Parameters:
- DATA_W, 16, payload width into the encoder and out of the decoder.
- NREQ, 2, number of requester ports (≥2).
- START_CYC, 3, cycles the encoder start strobe is held high.
- TIMEOUT_CYC, 4095, maximum cycles in WAIT before the transfer is aborted.
- GAP_CYC, 4, idle cycles enforced between transfers so the transmitter and receiver can settle.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset (asserted at 0).
- req_valid  in  NREQ  per-requester word valid.
- req_data  in  NREQ*DATA_W  packed words; requester i occupies bits [i*DATA_W +: DATA_W].
- req_ready  out  NREQ  one-hot accept pulse.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumer ready.
- rsp_data  out  DATA_W  decoded word.
- rsp_id  out  $clog2(NREQ)  originating requester.
- rsp_timeout  out  1  transfer aborted; rsp_data = 0.
- link_data  out  DATA_W  word to the encoder.
- link_start  out  1  encoder readready strobe.
- link_done  in  1  decoder writeready.
- link_rdata  in  DATA_W  decoder output.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (reset=0, async): state IDLE; every output 0; round-robin pointer = 0; counters cleared.
- IDLE: when any req_valid is high, go to ARB.
- ARB (1 cycle): round-robin grant, searching from ptr+1 (ptr = last grantee).
  - Pulse req_ready[g] for this one cycle.
  - Latch req_data[g] into link_data and g into the ID register.
  - Update ptr to g; go to LAUNCH.
  - If the requester drops valid during this cycle (illegal), the grant still completes.
- LAUNCH: link_start=1 for exactly START_CYC cycles; link_data held stable.
  - Then go to WAIT with link_start=0 and the timeout counter cleared.
- WAIT: the counter increments each cycle.
  - link_done=1: capture link_rdata; go to RESP with rsp_timeout=0.
  - Counter reaches TIMEOUT_CYC with no link_done: go to RESP with rsp_timeout=1 and rsp_data=0.
  - Timeout and link_done in the same cycle: link_done wins.
  - link_done seen in LAUNCH is ignored; it is a stale level from the previous transfer.
- RESP: rsp_valid=1; rsp_data, rsp_id and rsp_timeout are held until rsp_ready.
  - On the handshake cycle, rsp_valid drops next cycle and the state goes to GAP.
  - No new grant is issued while in RESP (backpressure stalls the link).
- GAP: idle for GAP_CYC cycles, then IDLE. If GAP_CYC = 0, go directly from RESP to IDLE.
- Latency, req_ready pulse to rsp_valid: 1 + START_CYC + N cycles, where N = cycles until link_done (≥1).
- link_data holds its value until the next ARB.
- A reset assertion mid-transfer aborts immediately.
  - No response is issued.
  - link_start drops asynchronously.
  - The pointer returns to 0.
- Widths: all counters are $clog2(max(TIMEOUT_CYC,START_CYC,GAP_CYC)+1) bits and never wrap; they saturate at the terminal compare.

Optional Feature:
- Macro LINK_SCHED_CHECK_EN.
- Defined:
  - The sent word is retained.
  - In RESP, an extra output rsp_mismatch = (rsp_data != sent word) && !rsp_timeout.
  - A 16-bit saturating err_count output increments once per mismatched or timed-out response, on the handshake.
  - err_count is cleared by reset.
- Undefined: neither port exists and no compare logic is generated.

Decomposition:
- Package link_sched_pkg holds:
  - state enum (IDLE, ARB, LAUNCH, WAIT, RESP, GAP);
  - DATA_W default;
  - id width function.
- Sub-module rr_arbiter (NREQ requests, pointer in, one-hot grant plus index out, combinational) instantiated once.

Test Plan:
- Single word: requester 0 sends 12345, link_done after 40 cycles with link_rdata=12345. Required: link_start high 3 cycles; rsp_valid with rsp_data=12345, rsp_id=0, rsp_timeout=0.
- Contention: both requesters valid continuously with words 10101 and 12345. Required: grants alternate 1,0,1,0 starting from requester 1; each rsp_id matches its grant.
- Timeout: TIMEOUT_CYC=20, link_done never asserts. Required: rsp_valid 20 cycles after WAIT entry with rsp_timeout=1, rsp_data=0; next request still served.
- Backpressure: rsp_ready held low 10 cycles. Required: rsp fields stable and no req_ready pulse until the handshake, then GAP of 4 cycles.
- Reset mid-WAIT: reset driven to 0 for 2 cycles. Required: all outputs 0 immediately; after release, requester 0 is served first.
- With LINK_SCHED_CHECK_EN: send 12345, return 12344. Required: rsp_mismatch=1 and err_count=1.
